span_load_sequencer: RTL and testbench
======================================

Name: span_load_sequencer

Overview:
- Sequencer that feeds one SPAN/CME margin computation into the span_cme register interface without host involvement.
- On a start command it streams NUM_WORDS parameter words from a synchronous parameter RAM into span_cme offsets 0..NUM_WORDS-1. Typical words: price, scenario deltas, scan ranges, cross-commodity fields.
- It then waits the fixed compute latency, reads the result word and presents it on a valid/ready output.
- Sits between the portfolio parameter RAM and span_cme; the host only issues start and consumes results.

Parameters:
- NUM_WORDS, 34, parameter words per computation (span_cme offsets 0..33)
- DATA_W, 16, word width (matches span_cme writeData/readData)
- ADDR_W, 10, parameter RAM address width
- OFF_W, 6, span_cme offset width
- COMPUTE_CYCLES, 200, idle cycles between last write and result read
- RESULT_OFF, 0, span_cme offset used for the result read

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  request one computation; sampled only in IDLE
- base_addr  in  ADDR_W  RAM address of word 0; captured with start
- abort  in  1  synchronous cancel; returns to IDLE
- busy  out  1  high whenever state != IDLE
- start_ignored  out  1  one-cycle pulse when start is seen outside IDLE
- mem_rd  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  DATA_W  RAM data, valid exactly 1 cycle after mem_rd
- cme_chipselect  out  1  span_cme chipselect
- cme_write  out  1  span_cme write strobe
- cme_read  out  1  span_cme read strobe
- cme_offset  out  OFF_W  span_cme register offset
- cme_writeData  out  DATA_W  span_cme write data
- cme_readData  in  DATA_W  span_cme read data, valid 1 cycle after cme_read
- res_valid  out  1  result available
- res_data  out  DATA_W  captured result
- res_ready  in  1  consumer accepts result

Behaviour:
- All outputs are registered.
- Reset values: all strobes 0, busy 0, start_ignored 0, res_valid 0, res_data 0, mem_addr 0, cme_offset 0, cme_writeData 0, state IDLE, counters 0.
- States: IDLE, LOAD, WAIT, RD, CAP, RESULT.
- IDLE:
  - start=1 (and abort=0) → capture base_addr, clear k, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: counter k runs 0..NUM_WORDS (35 cycles).
  - When k ≤ NUM_WORDS-1: mem_rd=1 and mem_addr=(base+k) mod 2^ADDR_W. The sum wraps; no error is raised.
  - When k ≥ 1: cme_chipselect=1, cme_write=1, cme_offset=k-1, cme_writeData=mem_rdata. The read and the write are pipelined, so the write lags the read by one cycle.
  - After k=NUM_WORDS → WAIT.
- WAIT: all cme/mem strobes 0 for exactly COMPUTE_CYCLES cycles, then → RD.
- RD: one cycle with cme_chipselect=1, cme_read=1, cme_offset=RESULT_OFF, cme_write=0 → CAP.
- CAP: res_data ← cme_readData; res_valid set to 1 on the next edge → RESULT.
- RESULT:
  - res_valid and res_data are held stable until res_valid & res_ready.
  - On that transfer edge, res_valid → 0 and the state → IDLE.
  - A new start is accepted no earlier than the cycle after the transfer.
- start while busy: the request is not queued; start_ignored pulses for 1 cycle per sampled start.
- abort:
  - Any state → IDLE on the next edge; strobes and res_valid are forced to 0.
  - abort has priority over start and over res_ready.
  - span_cme registers already written are left as-is.
- Reset asserted mid-operation: immediate return to reset values, independent of clk. The first start after deassertion performs a full reload.
- Start-to-res_valid latency: 1 (IDLE→LOAD) + 35 + COMPUTE_CYCLES + 1 + 1 = 238 cycles at the defaults.
- cme_write and cme_read are never high in the same cycle. mem_rd is never high outside LOAD.

Test Plan:
- Nominal load:
  - Stimulus: RAM[0x040..0x061] = 96, 10, 15, 0xFFF6, 0xFFEC, 5, …, 2, 1, 55; start with base_addr=0x040.
  - Required: 34 writes with offsets 0..33 and data exactly matching the RAM image (offset 0=96, offset 3=0xFFF6, offset 33=55), in consecutive cycles; first write 2 cycles after start is sampled.
- Result handshake:
  - Stimulus: after WAIT, cme_readData=0x1234; res_ready held low 5 cycles, then high.
  - Required: single cme_read at offset 0 exactly 200 cycles after the last write; res_valid=1 with res_data=0x1234 held stable for 5 cycles; transfer on the 6th; busy=0 the next cycle.
- Address wrap:
  - Stimulus: base_addr=0x3F0.
  - Required: mem_addr sequence 0x3F0..0x3FF, then 0x000..0x011 (34 reads); offsets still 0..33.
- Abort:
  - Stimulus: abort during LOAD right after the write to offset 10.
  - Required: no further writes, IDLE next cycle, res_valid never set; a following start reloads offsets 0..33.
- Start while busy / abort+start:
  - Stimulus: start pulses during WAIT and RESULT; then abort and start asserted in the same IDLE cycle.
  - Required: start_ignored pulses once per pulse, the in-flight computation is unaffected, abort wins and the FSM stays in IDLE.
- Reset mid-WAIT:
  - Stimulus: drive reset=0 at cycle 100 of WAIT.
  - Required: all outputs take reset values asynchronously; after release and a new start, a full 238-cycle sequence completes correctly.

Source files
------------

// File: rtl/span_load_sequencer.sv
// Streams one set of SPAN/CME parameter words from a parameter RAM into span_cme,
// waits out the compute latency, reads the result back and offers it on valid/ready.
module span_load_sequencer #(
  parameter int NUM_WORDS      = 34,
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 10,
  parameter int OFF_W          = 6,
  parameter int COMPUTE_CYCLES = 200,
  parameter int RESULT_OFF     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  output logic              busy,
  output logic              start_ignored,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cme_chipselect,
  output logic              cme_write,
  output logic              cme_read,
  output logic [OFF_W-1:0]  cme_offset,
  output logic [DATA_W-1:0] cme_writeData,
  input  logic [DATA_W-1:0] cme_readData,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready
);

  localparam int K_W = $clog2(NUM_WORDS + 1);
  localparam int W_W = $clog2(COMPUTE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RD,
    S_CAP,
    S_RESULT
  } state_t;

  state_t             state_reg, state_next;
  logic [K_W-1:0]     k_reg, k_next;
  logic [W_W-1:0]     wait_reg, wait_next;
  logic [ADDR_W-1:0]  base_reg, base_next;

  logic               busy_reg, busy_next;
  logic               start_ignored_reg, start_ignored_next;
  logic               mem_rd_reg, mem_rd_next;
  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic               cs_reg, cs_next;
  logic               wr_reg, wr_next;
  logic               rd_reg, rd_next;
  logic [OFF_W-1:0]   offset_reg, offset_next;
  logic [DATA_W-1:0]  wdata_reg, wdata_next;
  logic               res_valid_reg, res_valid_next;
  logic [DATA_W-1:0]  res_data_reg, res_data_next;

  always_comb begin
    state_next         = state_reg;
    k_next             = k_reg;
    wait_next          = wait_reg;
    base_next          = base_reg;
    mem_rd_next        = 1'b0;
    mem_addr_next      = mem_addr_reg;
    cs_next            = 1'b0;
    wr_next            = 1'b0;
    rd_next            = 1'b0;
    offset_next        = offset_reg;
    wdata_next         = wdata_reg;
    res_valid_next     = res_valid_reg;
    res_data_next      = res_data_reg;
    start_ignored_next = start && (state_reg != S_IDLE);

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          // Word 0 is requested on the accepting edge so the RAM pipeline starts at once.
          state_next    = S_LOAD;
          k_next        = '0;
          base_next     = base_addr;
          mem_rd_next   = 1'b1;
          mem_addr_next = base_addr;
        end
      end
      S_LOAD: begin
        k_next = k_reg + K_W'(1);
        if (k_reg != '0) begin
          cs_next     = 1'b1;
          wr_next     = 1'b1;
          offset_next = OFF_W'(k_reg - K_W'(1));
          wdata_next  = mem_rdata;
        end
        if (k_reg < K_W'(NUM_WORDS - 1)) begin
          mem_rd_next   = 1'b1;
          mem_addr_next = base_reg + ADDR_W'(k_reg) + ADDR_W'(1);
        end
        if (k_reg == K_W'(NUM_WORDS)) begin
          state_next = S_WAIT;
          k_next     = '0;
          wait_next  = '0;
        end
      end
      S_WAIT: begin
        // The first WAIT cycle still shows the last load write, so the idle gap on
        // the bus is exactly COMPUTE_CYCLES before the result read appears.
        wait_next = wait_reg + W_W'(1);
        if (wait_reg == W_W'(COMPUTE_CYCLES)) begin
          state_next  = S_RD;
          wait_next   = '0;
          cs_next     = 1'b1;
          rd_next     = 1'b1;
          offset_next = OFF_W'(RESULT_OFF);
        end
      end
      S_RD: begin
        state_next = S_CAP;
      end
      S_CAP: begin
        res_data_next  = cme_readData;
        res_valid_next = 1'b1;
        state_next     = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort) begin
      state_next     = S_IDLE;
      k_next         = '0;
      wait_next      = '0;
      mem_rd_next    = 1'b0;
      cs_next        = 1'b0;
      wr_next        = 1'b0;
      rd_next        = 1'b0;
      res_valid_next = 1'b0;
    end

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= S_IDLE;
      k_reg             <= '0;
      wait_reg          <= '0;
      base_reg          <= '0;
      busy_reg          <= 1'b0;
      start_ignored_reg <= 1'b0;
      mem_rd_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      cs_reg            <= 1'b0;
      wr_reg            <= 1'b0;
      rd_reg            <= 1'b0;
      offset_reg        <= '0;
      wdata_reg         <= '0;
      res_valid_reg     <= 1'b0;
      res_data_reg      <= '0;
    end else begin
      state_reg         <= state_next;
      k_reg             <= k_next;
      wait_reg          <= wait_next;
      base_reg          <= base_next;
      busy_reg          <= busy_next;
      start_ignored_reg <= start_ignored_next;
      mem_rd_reg        <= mem_rd_next;
      mem_addr_reg      <= mem_addr_next;
      cs_reg            <= cs_next;
      wr_reg            <= wr_next;
      rd_reg            <= rd_next;
      offset_reg        <= offset_next;
      wdata_reg         <= wdata_next;
      res_valid_reg     <= res_valid_next;
      res_data_reg      <= res_data_next;
    end
  end

  assign busy           = busy_reg;
  assign start_ignored  = start_ignored_reg;
  assign mem_rd         = mem_rd_reg;
  assign mem_addr       = mem_addr_reg;
  assign cme_chipselect = cs_reg;
  assign cme_write      = wr_reg;
  assign cme_read       = rd_reg;
  assign cme_offset     = offset_reg;
  assign cme_writeData  = wdata_reg;
  assign res_valid      = res_valid_reg;
  assign res_data       = res_data_reg;

endmodule

// File: tb/tb_span_load_sequencer.sv
// Randomized bench for span_load_sequencer: a time-indexed model of one computation
// (cycle t after the accepting edge) predicts every output on every cycle.
module tb_span_load_sequencer;

  localparam int NW      = 34;
  localparam int CC      = 200;
  localparam int RD_T    = NW + 2 + CC;   // cycle of the result read
  localparam int VALID_T = RD_T + 2;      // first cycle with res_valid

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, res_ready;
  logic [9:0]  base_addr;
  logic [15:0] mem_rdata, cme_readData;
  logic        busy, start_ignored, mem_rd, cme_chipselect, cme_write, cme_read, res_valid;
  logic [9:0]  mem_addr;
  logic [5:0]  cme_offset;
  logic [15:0] cme_writeData, res_data;

  span_load_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .abort(abort),
    .busy(busy), .start_ignored(start_ignored), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .cme_chipselect(cme_chipselect), .cme_write(cme_write),
    .cme_read(cme_read), .cme_offset(cme_offset), .cme_writeData(cme_writeData),
    .cme_readData(cme_readData), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:1023];
  logic [15:0] result_val;

  // Parameter RAM and span_cme read port; garbage whenever no read was issued.
  always @(posedge clk) begin
    mem_rdata    <= mem_rd ? ram[mem_addr] : 16'($urandom);
    cme_readData <= cme_read ? result_val : 16'($urandom);
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model state and monitor records
  bit          m_active, m_ign;
  int          m_t;
  logic [9:0]  m_base;
  logic [15:0] m_res;
  int          cyc, accept_cyc, first_write_cyc, last_write_cyc, read_cyc, valid_cyc, xfer_cyc;
  int          wr_count, rd_count, ign_count, txn_no;
  bit          valid_seen;
  logic [15:0] cme_regs [0:63];
  bit          written [0:63];
  logic [9:0]  rd_addrs [0:63];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_ign    = 1'b0;
      m_t      = 0;
    end else begin
      cyc   = cyc + 1;
      m_ign = start && m_active;
      if (abort) begin
        if (m_active) begin
          txn_no++;
          $display("txn %0d: aborted at t=%0d", txn_no, m_t);
        end
        m_active = 1'b0;
      end else if (!m_active) begin
        if (start) begin
          m_active        = 1'b1;
          m_t             = 0;
          m_base          = base_addr;
          m_res           = result_val;
          accept_cyc      = cyc;
          first_write_cyc = -1;
          wr_count        = 0;
          rd_count        = 0;
          ign_count       = 0;
          valid_seen      = 1'b0;
          for (int i = 0; i < 64; i++) written[i] = 1'b0;
        end
      end else if (m_t >= VALID_T && res_ready) begin
        m_active = 1'b0;
        xfer_cyc = cyc;
        txn_no++;
        $display("txn %0d: base=%03h result=%04h accepted after %0d cycles", txn_no, m_base, m_res, m_t + 1);
      end else begin
        m_t++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_values", {busy, start_ignored, mem_rd, mem_addr, cme_chipselect, cme_write,
                           cme_read, cme_offset, cme_writeData, res_valid, res_data}, 64'd0);
    end else begin
      bit exp_rd, exp_wr, exp_rq, exp_v;
      exp_rd = m_active && m_t <= NW - 1;
      exp_wr = m_active && m_t >= 2 && m_t <= NW + 1;
      exp_rq = m_active && m_t == RD_T;
      exp_v  = m_active && m_t >= VALID_T;
      chk("busy", busy, m_active);
      chk("start_ignored", start_ignored, m_ign);
      chk("mem_rd", mem_rd, exp_rd);
      if (exp_rd) chk("mem_addr", mem_addr, (int'(m_base) + m_t) % 1024);
      chk("cme_write", cme_write, exp_wr);
      chk("cme_read", cme_read, exp_rq);
      chk("cme_chipselect", cme_chipselect, exp_wr | exp_rq);
      if (exp_wr) begin
        chk("write_offset", cme_offset, m_t - 2);
        chk("write_data", cme_writeData, ram[(int'(m_base) + m_t - 2) % 1024]);
      end
      if (exp_rq) chk("read_offset", cme_offset, 0);
      chk("res_valid", res_valid, exp_v);
      if (exp_v) chk("res_data", res_data, m_res);
    end
  end

  // Bus monitor feeding the hand-computed checks.
  always @(negedge clk) begin
    if (reset) begin
      if (cme_write) begin
        wr_count++;
        cme_regs[cme_offset] = cme_writeData;
        written[cme_offset]  = 1'b1;
        last_write_cyc       = cyc;
        if (first_write_cyc < 0) first_write_cyc = cyc;
      end
      if (cme_read) read_cyc = cyc;
      if (mem_rd) begin
        if (rd_count < 64) rd_addrs[rd_count] = mem_addr;
        rd_count++;
      end
      if (start_ignored) ign_count++;
      if (res_valid && !valid_seen) begin
        valid_seen = 1'b1;
        valid_cyc  = cyc;
      end
    end
  end

  task automatic do_start(input logic [9:0] b);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 10'($urandom);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 800 && busy; n++) @(negedge clk);
    chk(name, busy, 1'b0);
  endtask

  task automatic wait_t(input int target);
    for (int n = 0; n < 400 && m_t != target; n++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [15:0] head [0:5];
    head[0] = 16'd96; head[1] = 16'd10; head[2] = 16'd15;
    head[3] = 16'hFFF6; head[4] = 16'hFFEC; head[5] = 16'd5;
    for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
    for (int i = 0; i < 6; i++) ram[10'h040 + i] = head[i];
    ram[10'h040 + 31] = 16'd2;
    ram[10'h040 + 32] = 16'd1;
    ram[10'h040 + 33] = 16'd55;
    cyc = 0; txn_no = 0; first_write_cyc = -1; xfer_cyc = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    base_addr = '0; result_val = 16'h1234;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // Nominal load, result handshake, stray starts during WAIT and RESULT
    do_start(10'h040);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 400 && !res_valid; n++) @(negedge clk);
    chk("nominal_valid_rises", res_valid, 1'b1);
    chk("nominal_res_data", res_data, 16'h1234);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("nominal_busy_after_xfer", busy, 1'b0);
    chk("nominal_first_write_lat", first_write_cyc - accept_cyc, 2);
    chk("nominal_write_count", wr_count, 34);
    chk("nominal_read_gap", read_cyc - last_write_cyc, CC + 1);
    chk("nominal_valid_latency", valid_cyc - accept_cyc, 238);
    chk("nominal_xfer_cycle", xfer_cyc - valid_cyc, 6);
    chk("nominal_off0", cme_regs[0], 16'd96);
    chk("nominal_off3", cme_regs[3], 16'hFFF6);
    chk("nominal_off33", cme_regs[33], 16'd55);
    chk("nominal_ignored_count", ign_count, 2);

    // Address wrap
    res_ready = 1'b1;
    result_val = 16'($urandom);
    do_start(10'h3F0);
    wait_idle("wrap_done");
    chk("wrap_read_count", rd_count, 34);
    chk("wrap_addr0", rd_addrs[0], 10'h3F0);
    chk("wrap_addr15", rd_addrs[15], 10'h3FF);
    chk("wrap_addr16", rd_addrs[16], 10'h000);
    chk("wrap_addr33", rd_addrs[33], 10'h011);
    chk("wrap_write_count", wr_count, 34);

    // Abort right after the write to offset 10, then a full reload
    do_start(10'h100);
    wait_t(12);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    repeat (300) @(negedge clk);
    chk("abort_write_count", wr_count, 11);
    chk("abort_no_valid", valid_seen, 1'b0);
    do_start(10'h100);
    wait_idle("reload_done");
    cnt = 0;
    for (int i = 0; i < NW; i++) cnt += int'(written[i]);
    chk("reload_offsets", cnt, 34);

    // abort and start together in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", busy, 1'b0);
    chk("abort_start_idle_ign", start_ignored, 1'b0);

    // Asynchronous reset in the middle of WAIT
    result_val = 16'($urandom);
    do_start(10'h200);
    wait_t(NW + 1 + 100);
    #2 reset = 1'b0;
    #1 chk("async_reset_outputs", {busy, mem_rd, cme_chipselect, cme_write, cme_read,
                                   mem_addr, cme_offset, cme_writeData, res_valid, res_data}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    do_start(10'h200);
    wait_idle("post_reset_done");
    chk("post_reset_writes", wr_count, 34);
    chk("post_reset_latency", valid_cyc - accept_cyc, 238);

    // Randomized transactions with random back-pressure, stray starts and aborts
    for (int r = 0; r < 12; r++) begin
      bit ab_en;
      int n;
      ab_en = (r % 3 == 2);
      result_val = 16'($urandom);
      do_start(10'($urandom));
      for (n = 0; n < 800 && m_active; n++) begin
        @(negedge clk);
        res_ready = 1'($urandom_range(0, 1));
        start     = m_active && ($urandom_range(0, 39) == 0);
        abort     = ab_en && ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      wait_idle("random_txn_done");
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
